fp_acc_seq_ctrl: RTL and testbench
==================================

// Module: fp_acc_seq_ctrl
// PURPOSE
//  Sequencer on the operand/result side of the combinational fp_acc adder.
//  Accepts a valid/ready stream of fp16/fp32/fp64 operands and drives adder i_A/i_B/mode_sel.
//  Captures o_r each beat into a running-sum register; emits one sum per burst on a valid/ready output.
//  Sits between the PE operand FIFO and the result writeback path; the adder is instantiated externally.
// PARAMETERS
//  MAX_BEATS  256  burst length cap; a burst auto-terminates on its MAX_BEATS-th beat
//  CNT_W      9    beat-counter width; must satisfy 2**CNT_W > MAX_BEATS
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous reset, active high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      operand beat accepted when in_valid&in_ready
//  in_data    in   64     operand, fp_acc packing (fp16 [15:0], fp32 [31:0], fp64 [63:0])
//  in_last    in   1      final beat of burst
//  in_mode    in   2      00 fp16, 01 fp32, 10 fp64; sampled on first beat of burst only
//  acc_a      out  64     to adder i_A = running-sum register
//  acc_b      out  64     to adder i_B = in_data (combinational pass-through)
//  acc_mode   out  2      to adder mode_sel = latched burst mode (first beat: in_mode)
//  acc_r      in   64     from adder o_r, same-cycle combinational result
//  out_valid  out  1      burst sum valid
//  out_ready  in   1      downstream accepts sum
//  out_data   out  64     burst sum, unused upper bits zero
//  out_count  out  CNT_W  beats accumulated in emitted burst
// BEHAVIOUR
//  States: IDLE (sum=0, no beat taken), ACC (burst open), OUT (sum held).
//  Reset: state=IDLE; sum, out_data, out_count, mode reg, count = 0; in_ready=0 on reset cycle.
//  IDLE/ACC: in_ready=1, out_valid=0. OUT: in_ready=0, out_valid=1 until out_ready.
//  Accepted beat: sum<=acc_r; count<=count+1; in IDLE also mode<=in_mode, state->ACC.
//  acc_mode = (state==IDLE) ? in_mode : mode reg; in_mode ignored while ACC.
//  End of burst: accepted beat with in_last=1 OR count+1==MAX_BEATS (single event if both):
//   out_data<=acc_r, out_count<=count+1, state->OUT next cycle; latency 1 cycle from last beat.
//  Single-beat burst from IDLE (in_last=1) -> OUT directly; out_data = 0+x = x.
//  OUT with out_ready=1: state->IDLE, sum<=0, count<=0; in_ready=1 the following cycle.
//  No accepted beat -> sum/count/state hold (bubbles allowed mid-burst).
//  Mode 11: beats accepted normally; adder yields 0; out_data=0, out_count valid.
//  Reset mid-burst or mid-OUT: partial sum discarded, no output emitted.
//  out_data/out_count stable while out_valid=1 and out_ready=0.
// CONFIGURATION
//  FP_ACC_SEQ_OVF_FLAG_EN defined: extra port out_ovf (out,1), valid with out_data;
//   set when any accepted beat's acc_r exponent field is all ones for latched mode
//   (fp16 [14:10]=1f, fp32 [30:23]=ff, fp64 [62:52]=7ff); sticky within burst; cleared
//   on out handshake and reset.
//  Undefined: no out_ovf port; no overflow tracking logic.
// TESTING
//  fp32 beats 3F800000, 40000000(last) -> out_data=0000_0000_4040_0000, out_count=2, latency 1.
//  fp16 four beats 3C00, in_last on 4th, mode=01 driven after beat 1 -> out_data=0x4400, mode 00 held.
//  fp32 MAX_BEATS=4, six beats 3F800000, no in_last -> out 40800000 cnt 4; in_ready=0 until drained.
//  fp64 3FF0000000000000 (last), out_ready=0 for 5 cycles -> out_valid/out_data held, in_ready=0.
//  fp32 7F000000 x2 (last) with _EN -> out_data[30:23]=ff, out_ovf=1; next 3F800000 burst out_ovf=0.
//  rst asserted after 2 of 3 beats -> no out_valid; next fp32 burst 40000000(last) -> out 40000000.

Source files
------------

// File: rtl/fp_acc_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fp_acc_seq_ctrl_if                                            |
// | Brief    : Operand stream, adder-side and result stream signals of the   |
// |            fp_acc sequencer, bundled with master/slave views.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface fp_acc_seq_ctrl_if #(
   parameter int CNT_W = 9
);
   // operand stream
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      in_data;
   logic             in_last;
   logic [1:0]       in_mode;
   // external combinational adder
   logic [63:0]      acc_a;
   logic [63:0]      acc_b;
   logic [1:0]       acc_mode;
   logic [63:0]      acc_r;
   // result stream
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_data;
   logic [CNT_W-1:0] out_count;

   // environment side: operand source, adder, result sink
   modport master (
      output in_valid, in_data, in_last, in_mode, acc_r, out_ready,
      input  in_ready, acc_a, acc_b, acc_mode, out_valid, out_data, out_count
   );

   // sequencer side
   modport slave (
      input  in_valid, in_data, in_last, in_mode, acc_r, out_ready,
      output in_ready, acc_a, acc_b, acc_mode, out_valid, out_data, out_count
   );
endinterface
`default_nettype wire

// File: rtl/fp_acc_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fp_acc_seq_ctrl                                               |
// | Brief    : Burst sequencer around an external combinational fp_acc      |
// |            adder. Feeds running sum and operand to the adder, captures  |
// |            its result each accepted beat and emits one sum per burst.   |
// | Options  : FP_ACC_SEQ_OVF_FLAG_EN adds out_ovf (exponent all-ones seen   |
// |            on any beat of the emitted burst).                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fp_acc_seq_ctrl #(
   parameter int MAX_BEATS = 256,
   parameter int CNT_W     = 9
) (
   input  logic             clk,
   input  logic             rst,
`ifdef FP_ACC_SEQ_OVF_FLAG_EN
   output logic             out_ovf,
`endif
   fp_acc_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_max_beats = CNT_W'(MAX_BEATS);

   state_t           state_q, state_d;
   logic [63:0]      sum_q, sum_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       mode_q, mode_d;
   logic [63:0]      out_data_q, out_data_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;

   logic             fire;
   logic             burst_end;
   logic [CNT_W-1:0] count_inc;
   logic [1:0]       acc_mode;

   // Handshakes and adder drive; the first beat uses in_mode directly since
   // the mode register is only loaded on that same edge
   always_comb begin
      bus.in_ready  = (state_q != OUT) && !rst;
      bus.out_valid = (state_q == OUT);
      acc_mode      = (state_q == IDLE) ? bus.in_mode : mode_q;
      bus.acc_mode  = acc_mode;
      bus.acc_a     = sum_q;
      bus.acc_b     = bus.in_data;
      bus.out_data  = out_data_q;
      bus.out_count = out_count_q;
      fire          = bus.in_valid && bus.in_ready;
      count_inc     = count_q + 1'b1;
      // in_last and the beat cap coincide into a single end-of-burst event
      burst_end     = fire && (bus.in_last || (count_inc == c_max_beats));
   end

   // Next-state: accumulate accepted beats, close the burst, drain the result
   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      count_d     = count_q;
      mode_d      = mode_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      case (state_q)
         IDLE, ACC: begin
            if (fire) begin
               sum_d   = bus.acc_r;
               count_d = count_inc;
               if (state_q == IDLE) begin
                  mode_d  = bus.in_mode;
                  state_d = ACC;
               end
               if (burst_end) begin
                  out_data_d  = bus.acc_r;
                  out_count_d = count_inc;
                  state_d     = OUT;
               end
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               sum_d   = '0;
               count_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            sum_d   = '0;
            count_d = '0;
         end
      endcase
   end

   // State and datapath registers; reset drops any partial burst
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         count_q     <= '0;
         mode_q      <= '0;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         count_q     <= count_d;
         mode_q      <= mode_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

`ifdef FP_ACC_SEQ_OVF_FLAG_EN
   logic exp_all_ones;
   logic ovf_q, ovf_d;
   logic out_ovf_q, out_ovf_d;

   // Exponent field of the adder result is all ones for the active mode
   always_comb begin
      exp_all_ones = 1'b0;
      case (acc_mode)
         2'b00:   exp_all_ones = &bus.acc_r[14:10];
         2'b01:   exp_all_ones = &bus.acc_r[30:23];
         2'b10:   exp_all_ones = &bus.acc_r[62:52];
         default: exp_all_ones = 1'b0;
      endcase
   end

   // Sticky within the burst, snapshotted at burst end, cleared on drain
   always_comb begin
      ovf_d     = ovf_q;
      out_ovf_d = out_ovf_q;
      if (fire) begin
         ovf_d = ovf_q | exp_all_ones;
         if (burst_end) begin
            out_ovf_d = ovf_q | exp_all_ones;
         end
      end
      if ((state_q == OUT) && bus.out_ready) begin
         ovf_d     = 1'b0;
         out_ovf_d = 1'b0;
      end
   end

   // Overflow flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q     <= 1'b0;
         out_ovf_q <= 1'b0;
      end else begin
         ovf_q     <= ovf_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign out_ovf = out_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_acc_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fp_acc_seq_ctrl                                            |
// | Brief    : Self-checking bench for fp_acc_seq_ctrl with a behavioural    |
// |            adder (positive normals, truncating) and burst-level model.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fp_acc_seq_ctrl;

   localparam int MAX_BEATS = 4;
   localparam int CNT_W     = 3;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [63:0] bdata[$];

   always #5 clk = ~clk;

   fp_acc_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

`ifdef FP_ACC_SEQ_OVF_FLAG_EN
   logic out_ovf;
`endif

   fp_acc_seq_ctrl #(
      .MAX_BEATS(MAX_BEATS),
      .CNT_W    (CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
`ifdef FP_ACC_SEQ_OVF_FLAG_EN
      .out_ovf(out_ovf),
`endif
      .bus    (bus)
   );

   // Format widths per mode: exponent / mantissa
   function automatic int exp_w(input logic [1:0] m);
      return (m == 2'd0) ? 5 : (m == 2'd1) ? 8 : 11;
   endfunction
   function automatic int man_w(input logic [1:0] m);
      return (m == 2'd0) ? 10 : (m == 2'd1) ? 23 : 52;
   endfunction

   // Behavioural floating-point add for positive operands; zero exponent is
   // treated as zero, exponent overflow saturates to infinity, mode 3 gives 0
   function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] m);
      int ew, mw, d;
      logic [63:0] emask, mmask, ea, eb, ma, mb, s, e, t;
      if (m == 2'd3) return 64'd0;
      ew = exp_w(m);
      mw = man_w(m);
      emask = (64'd1 << ew) - 64'd1;
      mmask = (64'd1 << mw) - 64'd1;
      ea = (a >> mw) & emask;
      eb = (b >> mw) & emask;
      ma = a & mmask;
      mb = b & mmask;
      if (ea == 64'd0) return (eb == 64'd0) ? 64'd0 : ((eb << mw) | mb);
      if (eb == 64'd0) return (ea << mw) | ma;
      if (eb > ea) begin
         t = ea; ea = eb; eb = t;
         t = ma; ma = mb; mb = t;
      end
      d  = int'(ea - eb);
      ma = ma | (64'd1 << mw);
      mb = mb | (64'd1 << mw);
      mb = (d >= 64) ? 64'd0 : (mb >> d);
      s  = ma + mb;
      e  = ea;
      if ((s >> (mw + 1)) != 64'd0) begin
         s = s >> 1;
         e = e + 64'd1;
      end
      if (e >= emask) return emask << mw;
      return (e << mw) | (s & mmask);
   endfunction

   function automatic bit exp_ones(input logic [63:0] v, input logic [1:0] m);
      logic [63:0] emask;
      if (m == 2'd3) return 1'b0;
      emask = (64'd1 << exp_w(m)) - 64'd1;
      return ((v >> man_w(m)) & emask) == emask;
   endfunction

   function automatic logic [63:0] rnd_op(input logic [1:0] m);
      logic [63:0] r;
      r = {$urandom, $urandom};
      case (m)
         2'd0:    return {48'd0, 1'b0, 5'(12 + $urandom_range(6, 0)), r[9:0]};
         2'd1:    return {32'd0, 1'b0, 8'(124 + $urandom_range(6, 0)), r[22:0]};
         2'd2:    return {1'b0, 11'(1020 + $urandom_range(6, 0)), r[51:0]};
         default: return r;
      endcase
   endfunction

   // The external adder
   always_comb bus.acc_r = fadd(bus.acc_a, bus.acc_b, bus.acc_mode);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one burst from bdata; the burst ends on last_idx or the beat cap.
   // Then hold the result for 'stall' cycles before draining it.
   task automatic burst(input logic [1:0] mode, input int n, input int last_idx,
                        input int bub, input int stall);
      logic [63:0] sum;
      bit          ovf;
      int          cnt;
      int          nb;
      sum = 64'd0;
      ovf = 1'b0;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         nb = $urandom_range(bub, 0);
         repeat (nb) begin
            bus.in_valid = 1'b0;
            bus.in_data  = {$urandom, $urandom};
            bus.in_last  = 1'($urandom);
            bus.in_mode  = 2'($urandom);
            #2;
            check("bubble_in_ready", 64'(bus.in_ready), 64'd1);
            check("bubble_out_valid", 64'(bus.out_valid), 64'd0);
            check("bubble_acc_a", bus.acc_a, sum);
            tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = bdata[i];
         bus.in_last  = (i == last_idx);
         bus.in_mode  = (i == 0) ? mode : (mode ^ 2'b01);
         #2;
         check("beat_in_ready", 64'(bus.in_ready), 64'd1);
         check("beat_acc_a", bus.acc_a, sum);
         check("beat_acc_b", bus.acc_b, bdata[i]);
         check("beat_acc_mode", 64'(bus.acc_mode), 64'(mode));
         sum = fadd(sum, bdata[i], mode);
         ovf = ovf | exp_ones(sum, mode);
         cnt++;
         tick();
         if ((i == last_idx) || (cnt == MAX_BEATS)) break;
      end
      // result phase: inputs may keep offering beats, none may be taken
      bus.in_valid  = 1'($urandom);
      bus.in_data   = rnd_op(mode);
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      for (int s = 0; s <= stall; s++) begin
         if (s == stall) bus.out_ready = 1'b1;
         #2;
         check("out_valid", 64'(bus.out_valid), 64'd1);
         check("out_data", bus.out_data, sum);
         check("out_count", 64'(bus.out_count), 64'(cnt));
         check("out_in_ready", 64'(bus.in_ready), 64'd0);
`ifdef FP_ACC_SEQ_OVF_FLAG_EN
         check("out_ovf", 64'(out_ovf), 64'(ovf));
`endif
         tick();
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      #2;
      check("drain_out_valid", 64'(bus.out_valid), 64'd0);
      check("drain_in_ready", 64'(bus.in_ready), 64'd1);
      check("drain_acc_a", bus.acc_a, 64'd0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n, li;
      logic [1:0] m;
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 64'h3F80_0000;
      bus.in_last   = 1'b1;
      bus.in_mode   = 2'b01;
      bus.out_ready = 1'b0;
      #1;
      tick();
      #2;
      check("reset_in_ready", 64'(bus.in_ready), 64'd0);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #2;
      check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
      check("post_reset_acc_a", bus.acc_a, 64'd0);
      check("post_reset_out_data", bus.out_data, 64'd0);
      check("post_reset_out_count", 64'(bus.out_count), 64'd0);
      tick();

      // fp32 1.0 + 2.0
      bdata = {64'h3F80_0000, 64'h4000_0000};
      burst(2'b01, 2, 1, 0, 0);
      // fp16 four 1.0 beats, mode changes after the first beat are ignored
      bdata = {64'h3C00, 64'h3C00, 64'h3C00, 64'h3C00};
      burst(2'b00, 4, 3, 0, 0);
      // fp32 six 1.0 beats without in_last: cap closes the first four
      bdata = {64'h3F80_0000, 64'h3F80_0000, 64'h3F80_0000, 64'h3F80_0000};
      burst(2'b01, 4, 99, 0, 2);
      bdata = {64'h3F80_0000, 64'h3F80_0000};
      burst(2'b01, 2, 1, 0, 0);
      // fp64 single beat held for five cycles
      bdata = {64'h3FF0_0000_0000_0000};
      burst(2'b10, 1, 0, 0, 5);
      // mode 11: beats counted, sum zero
      bdata = {64'h1234, 64'h5678, 64'h9ABC};
      burst(2'b11, 3, 2, 1, 1);
`ifdef FP_ACC_SEQ_OVF_FLAG_EN
      bdata = {64'h7F00_0000, 64'h7F00_0000};
      burst(2'b01, 2, 1, 0, 0);
      bdata = {64'h3F80_0000};
      burst(2'b01, 1, 0, 0, 0);
`endif

      // reset after two of three beats discards the partial sum
      bus.in_valid = 1'b1;
      bus.in_data  = 64'h3F80_0000;
      bus.in_last  = 1'b0;
      bus.in_mode  = 2'b01;
      tick();
      tick();
      rst         = 1'b1;
      bus.in_last = 1'b1;
      #2;
      check("midburst_rst_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #2;
      check("midburst_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midburst_rst_acc_a", bus.acc_a, 64'd0);
      tick();
      bdata = {64'h4000_0000};
      burst(2'b01, 1, 0, 0, 0);

      // reset while a result is held drops it
      bus.in_valid = 1'b1;
      bus.in_data  = 64'h3F80_0000;
      bus.in_last  = 1'b1;
      bus.in_mode  = 2'b01;
      tick();
      bus.in_valid = 1'b0;
      #2;
      check("midout_out_valid", 64'(bus.out_valid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      check("midout_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midout_rst_out_data", bus.out_data, 64'd0);
      check("midout_rst_out_count", 64'(bus.out_count), 64'd0);
      tick();

      // randomized bursts
      for (int k = 0; k < 30; k++) begin
         m  = 2'($urandom_range(3, 0));
         n  = $urandom_range(6, 1);
         li = $urandom_range(7, 0);
         if ((n < MAX_BEATS) && (li >= n)) li = n - 1;
         bdata = {};
         for (int j = 0; j < n; j++) bdata.push_back(rnd_op(m));
         burst(m, n, li, 2, $urandom_range(3, 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
